round_key_add: RTL

ROUND_KEY_ADD -- requirements
Module: round_key_add

---
 rtl/round_key_add_pkg.sv | 73 +++++++
 rtl/aes_sbox.sv | 14 +
 rtl/round_key_add.sv | 107 ++++++++++
 3 files changed

// File: rtl/round_key_add_pkg.sv
// Shared AES constants, types and GF(2^8) helpers for the round-key datapath.
package round_key_add_pkg;

  localparam int unsigned STATE_W    = 128;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned NR_DEFAULT = 10;
  localparam int unsigned RND_W      = 4;

  typedef logic [0:STATE_W-1] block_t;
  typedef logic [0:WORD_W-1]  word_t;

  typedef enum logic {NOKEY, RUN} rka_state_e;

  // Round constant table, indexed 1..10.
  function automatic logic [BYTE_W-1:0] rcon(input logic [RND_W-1:0] idx);
    logic [BYTE_W-1:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Multiply by x modulo the AES polynomial.
  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [BYTE_W-1:0] gf_mul(input logic [BYTE_W-1:0] a,
                                               input logic [BYTE_W-1:0] b);
    logic [BYTE_W-1:0] r;
    logic [BYTE_W-1:0] p;
    r = 8'h00;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = xtime(p);
    end
    return r;
  endfunction

  // Inverse as a^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [BYTE_W-1:0] gf_inv(input logic [BYTE_W-1:0] a);
    logic [BYTE_W-1:0] r;
    logic [BYTE_W-1:0] p;
    r = 8'h01;
    p = a;
    for (int k = 1; k < 8; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  // Forward S-box: field inverse followed by the affine transform.
  function automatic logic [BYTE_W-1:0] sbox_fn(input logic [BYTE_W-1:0] a);
    logic [BYTE_W-1:0] v;
    v = gf_inv(a);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^
           {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte.
module aes_sbox
  import round_key_add_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  output logic [BYTE_W-1:0] y
);

  // Pure lookup, computed algebraically.
  always_comb begin
    y = sbox_fn(a);
  end

endmodule

// File: rtl/round_key_add.sv
// AddRoundKey stage with on-the-fly AES-128 key expansion, one key per block round.
module round_key_add
  import round_key_add_pkg::*;
#(
  parameter int unsigned NR = NR_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_load,
  input  logic [0:STATE_W-1] key_in,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [0:STATE_W-1] state_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [0:STATE_W-1] state_out,
  output logic [RND_W-1:0]   out_round,
  output logic               out_last
);

  rka_state_e       state_q;
  rka_state_e       state_d;
  block_t           rk;
  block_t           saved_key;
  block_t           rk_next;
  logic [RND_W-1:0] rnd;
  word_t            rot_w;
  word_t            sub_w;
  word_t            nw0;
  word_t            nw1;
  word_t            nw2;
  word_t            nw3;
  logic             xfer_in;
  logic             xfer_out;
  logic             rnd_is_last;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= NOKEY;
    else     state_q <= state_d;
  end

  // Next state: any key load arms the block; only reset disarms it.
  always_comb begin
    state_d = state_q;
    if (key_load) state_d = RUN;
  end

  // Handshake: a pending output must drain before a new input is taken.
  always_comb begin
    in_ready    = (state_q == RUN) && !key_load && (!out_valid || out_ready);
    xfer_in     = in_valid && in_ready;
    xfer_out    = out_valid && out_ready;
    rnd_is_last = (rnd == RND_W'(NR));
  end

  // SubWord(RotWord(w3)) through four shared S-box instances.
  assign rot_w = {rk[104:127], rk[96:103]};
  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .a (rot_w[g*BYTE_W +: BYTE_W]),
      .y (sub_w[g*BYTE_W +: BYTE_W])
    );
  end

  // Next round key from the current one.
  always_comb begin
    nw0     = rk[0:31] ^ sub_w ^ {rcon(RND_W'(rnd + 4'd1)), 24'h000000};
    nw1     = rk[32:63] ^ nw0;
    nw2     = rk[64:95] ^ nw1;
    nw3     = rk[96:127] ^ nw2;
    rk_next = {nw0, nw1, nw2, nw3};
  end

  // Datapath: key/round tracking and the registered output slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rk        <= '0;
      saved_key <= '0;
      rnd       <= '0;
      out_valid <= 1'b0;
      state_out <= '0;
      out_round <= '0;
      out_last  <= 1'b0;
    end else if (key_load) begin
      rk        <= key_in;
      saved_key <= key_in;
      rnd       <= '0;
      out_valid <= 1'b0;
    end else if (xfer_in) begin
      state_out <= state_in ^ rk;
      out_round <= rnd;
      out_last  <= rnd_is_last;
      out_valid <= 1'b1;
      if (rnd_is_last) begin
        rk  <= saved_key;
        rnd <= '0;
      end else begin
        rk  <= rk_next;
        rnd <= RND_W'(rnd + 4'd1);
      end
    end else if (xfer_out) begin
      out_valid <= 1'b0;
    end
  end

endmodule
